// File: rtl/threshold_config_sequencer_pkg.sv
// rtl/threshold_config_sequencer_pkg.sv - shared sizes, opcodes and FSM state type for the threshold sequencer
package thr_cfg_pkg;

  localparam int NUM_CH = 40;
  localparam int TH_W   = 32;
  localparam int CH_W   = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_BCAST = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_CAP,
    S_BC_WR,
    S_BC_RD_ADDR,
    S_BC_RD_WAIT,
    S_BC_CMP,
    S_RSP
  } state_t;

endpackage

// File: rtl/threshold_config_sequencer_if.sv
// rtl/threshold_config_sequencer_if.sv - command, response and threshold-bank signals of the sequencer
interface threshold_config_sequencer_if #(
  parameter int TH_W = thr_cfg_pkg::TH_W
);
  import thr_cfg_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [CH_W-1:0]     cmd_ch;
  logic [TH_W-1:0]     cmd_value;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [TH_W-1:0]     rsp_data;
  logic [CH_W-1:0]     rsp_ch;
  logic                rsp_err;

  logic                write_threshold_value;
  logic [CH_W-1:0]     threshold_ch;
  logic [TH_W-1:0]     threshold_value;
  logic [TH_W-1:0]     threshold_value_read;

  logic                busy;

  // master: host plus threshold bank; slave: the sequencer
  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_value, rsp_ready, threshold_value_read,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ch, rsp_err,
           write_threshold_value, threshold_ch, threshold_value, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_value, rsp_ready, threshold_value_read,
    output cmd_ready, rsp_valid, rsp_data, rsp_ch, rsp_err,
           write_threshold_value, threshold_ch, threshold_value, busy
  );

endinterface

// File: rtl/threshold_config_sequencer.sv
// rtl/threshold_config_sequencer.sv - host command sequencer for single/broadcast threshold bank access
module threshold_config_sequencer
  import thr_cfg_pkg::*;
#(
  parameter int NUM_CH = thr_cfg_pkg::NUM_CH,
  parameter int TH_W   = thr_cfg_pkg::TH_W
) (
  input  logic                          clk,
  input  logic                          reset,
  threshold_config_sequencer_if.slave   bus
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t              state;
  logic                wtv_q;
  logic [CH_W-1:0]     th_ch_q;
  logic [TH_W-1:0]     th_val_q;
  logic                rsp_valid_q;
  logic [TH_W-1:0]     rsp_data_q;
  logic [CH_W-1:0]     rsp_ch_q;
  logic                rsp_err_q;
  logic [CH_W-1:0]     cmd_ch_q;
  logic [TH_W-1:0]     cmd_val_q;
  logic [CH_W-1:0]     ch_cnt;
  logic [CH_W:0]       mis_cnt;

  logic                ch_bad;
  logic                bc_mismatch;
  logic [CH_W:0]       mis_next;

  assign ch_bad      = (int'(bus.cmd_ch) >= NUM_CH);
  assign bc_mismatch = ($signed(bus.threshold_value_read) != $signed(cmd_val_q));
  assign mis_next    = mis_cnt + {{CH_W{1'b0}}, bc_mismatch};

  assign bus.cmd_ready             = (state == S_IDLE);
  assign bus.busy                  = (state != S_IDLE);
  assign bus.write_threshold_value = wtv_q;
  assign bus.threshold_ch          = th_ch_q;
  assign bus.threshold_value       = th_val_q;
  assign bus.rsp_valid             = rsp_valid_q;
  assign bus.rsp_data              = rsp_data_q;
  assign bus.rsp_ch                = rsp_ch_q;
  assign bus.rsp_err               = rsp_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wtv_q       <= 1'b0;
      th_ch_q     <= '0;
      th_val_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ch_q    <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ch_q    <= '0;
      cmd_val_q   <= '0;
      ch_cnt      <= '0;
      mis_cnt     <= '0;
    end else begin
      // write strobe is a one-cycle pulse unless a write state re-arms it
      wtv_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ch_q  <= bus.cmd_ch;
            cmd_val_q <= bus.cmd_value;
            ch_cnt    <= '0;
            mis_cnt   <= '0;
            case (cmd_op_t'(bus.cmd_op))
              OP_WRITE, OP_READ: begin
                if (ch_bad) begin
                  state       <= S_RSP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_ch_q    <= bus.cmd_ch;
                end else if (cmd_op_t'(bus.cmd_op) == OP_WRITE) begin
                  state    <= S_WR;
                  wtv_q    <= 1'b1;
                  th_ch_q  <= bus.cmd_ch;
                  th_val_q <= bus.cmd_value;
                end else begin
                  state <= S_RD_ADDR;
                end
              end
              OP_BCAST: begin
                state    <= S_BC_WR;
                wtv_q    <= 1'b1;
                th_ch_q  <= '0;
                th_val_q <= bus.cmd_value;
                rsp_ch_q <= '0;
              end
              default: begin
                state       <= S_RSP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_data_q  <= '0;
                rsp_ch_q    <= bus.cmd_ch;
              end
            endcase
          end
        end

        S_WR: begin
          state       <= S_RSP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= cmd_val_q;
          rsp_ch_q    <= cmd_ch_q;
        end

        S_RD_ADDR: begin
          th_ch_q <= cmd_ch_q;
          state   <= S_RD_WAIT;
        end

        S_RD_WAIT: state <= S_RD_CAP;

        // bank readback is registered, so it is valid on the second edge after the address
        S_RD_CAP: begin
          state       <= S_RSP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= bus.threshold_value_read;
          rsp_ch_q    <= cmd_ch_q;
        end

        S_BC_WR: begin
          if (ch_cnt == LAST_CH) begin
            ch_cnt <= '0;
            state  <= S_BC_RD_ADDR;
          end else begin
            ch_cnt  <= ch_cnt + 1'b1;
            wtv_q   <= 1'b1;
            th_ch_q <= ch_cnt + 1'b1;
          end
        end

        S_BC_RD_ADDR: begin
          th_ch_q <= ch_cnt;
          state   <= S_BC_RD_WAIT;
        end

        S_BC_RD_WAIT: state <= S_BC_CMP;

        S_BC_CMP: begin
          mis_cnt <= mis_next;
          if (bc_mismatch && (mis_cnt == '0)) begin
            rsp_ch_q <= ch_cnt;
          end
          if (ch_cnt == LAST_CH) begin
            ch_cnt      <= '0;
            state       <= S_RSP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= (mis_next != '0);
            rsp_data_q  <= TH_W'(mis_next);
          end else begin
            ch_cnt <= ch_cnt + 1'b1;
            state  <= S_BC_RD_ADDR;
          end
        end

        S_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_threshold_config_sequencer.sv
// tb/tb_threshold_config_sequencer.sv - directed self-checking bench for threshold_config_sequencer
module tb_threshold_config_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  threshold_config_sequencer_if #(.TH_W(32)) bus ();

  threshold_config_sequencer #(.NUM_CH(40), .TH_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // threshold bank model: registered readback, optional corruption of ch 7 and 22
  logic [31:0] bank [0:39] = '{default: 32'h0};
  logic        corrupt = 1'b0;
  int          wr_cnt = 0;
  logic [7:0]  last_wr_ch = 8'h0;

  always @(posedge clk) begin
    if (bus.write_threshold_value && bus.threshold_ch < 8'd40)
      bank[bus.threshold_ch] <= (corrupt && (bus.threshold_ch == 8'd7 || bus.threshold_ch == 8'd22))
                                ? bus.threshold_value + 32'd1 : bus.threshold_value;
    bus.threshold_value_read <= (bus.threshold_ch < 8'd40) ? bank[bus.threshold_ch] : 32'h0;
    if (bus.write_threshold_value) begin
      wr_cnt     <= wr_cnt + 1;
      last_wr_ch <= bus.threshold_ch;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] ch, input logic [31:0] val);
    int n;
    bus.cmd_op    = op;
    bus.cmd_ch    = ch;
    bus.cmd_value = val;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      step;
      n++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    step;
    bus.cmd_valid = 1'b0;
  endtask

  // k = edges after the accept edge until rsp_valid is seen
  task automatic wait_rsp(output int k);
    k = 0;
    while (!bus.rsp_valid && k < 400) begin
      step;
      k++;
    end
    chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic finish_rsp;
    bus.rsp_ready = 1'b1;
    step;
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int k;
    int base;
    logic [7:0] ch_before;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_ch    = 8'h0;
    bus.cmd_value = 32'h0;
    bus.rsp_ready = 1'b0;

    // reset state
    step;
    step;
    chk("rst_wtv", 32'(bus.write_threshold_value), 32'd0);
    chk("rst_th_ch", 32'(bus.threshold_ch), 32'd0);
    chk("rst_th_val", bus.threshold_value, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_ch", 32'(bus.rsp_ch), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    step;
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // write ch5 = 1234
    base = wr_cnt;
    send(2'b00, 8'd5, 32'd1234);
    chk("wr_pulse", 32'(bus.write_threshold_value), 32'd1);
    chk("wr_ch", 32'(bus.threshold_ch), 32'd5);
    chk("wr_val", bus.threshold_value, 32'd1234);
    chk("wr_busy", 32'(bus.busy), 32'd1);
    wait_rsp(k);
    chk("wr_lat", k, 32'd1);
    chk("wr_pulse_cnt", wr_cnt - base, 32'd1);
    chk("wr_wtv_low", 32'(bus.write_threshold_value), 32'd0);
    chk("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("wr_rsp_data", bus.rsp_data, 32'd1234);
    chk("wr_rsp_ch", 32'(bus.rsp_ch), 32'd5);
    finish_rsp;

    // write ch6 = 77 so a too-early capture of ch5 would return 77
    send(2'b00, 8'd6, 32'd77);
    wait_rsp(k);
    chk("wr6_rsp_data", bus.rsp_data, 32'd77);
    finish_rsp;

    // read ch5
    base = wr_cnt;
    send(2'b01, 8'd5, 32'd0);
    chk("rd_addr_wtv", 32'(bus.write_threshold_value), 32'd0);
    wait_rsp(k);
    chk("rd_lat", k, 32'd3);
    chk("rd_th_ch", 32'(bus.threshold_ch), 32'd5);
    chk("rd_rsp_data", bus.rsp_data, 32'd1234);
    chk("rd_rsp_ch", 32'(bus.rsp_ch), 32'd5);
    chk("rd_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rd_no_write", wr_cnt - base, 32'd0);
    finish_rsp;

    // read out-of-range ch40
    base = wr_cnt;
    ch_before = bus.threshold_ch;
    send(2'b01, 8'd40, 32'd0);
    wait_rsp(k);
    chk("bad_lat", k, 32'd0);
    chk("bad_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("bad_rsp_data", bus.rsp_data, 32'd0);
    chk("bad_rsp_ch", 32'(bus.rsp_ch), 32'd40);
    chk("bad_no_write", wr_cnt - base, 32'd0);
    chk("bad_ch_hold", 32'(bus.threshold_ch), 32'(ch_before));
    finish_rsp;

    // reserved op
    send(2'b11, 8'd3, 32'd99);
    wait_rsp(k);
    chk("rsv_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("rsv_rsp_data", bus.rsp_data, 32'd0);
    chk("rsv_no_write", wr_cnt - base, 32'd0);
    finish_rsp;

    // response backpressure with a second command pending
    send(2'b00, 8'd3, 32'd42);
    wait_rsp(k);
    bus.cmd_op    = 2'b01;
    bus.cmd_ch    = 8'd3;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data", bus.rsp_data, 32'd42);
      chk("bp_rsp_ch", 32'(bus.rsp_ch), 32'd3);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      step;
    end
    bus.rsp_ready = 1'b1;
    step;
    bus.rsp_ready = 1'b0;
    chk("bp_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);
    step;
    bus.cmd_valid = 1'b0;
    chk("bp_accept_busy", 32'(bus.busy), 32'd1);
    wait_rsp(k);
    chk("bp_rd_lat", k, 32'd3);
    chk("bp_rd_data", bus.rsp_data, 32'd42);
    finish_rsp;

    // broadcast -500 with ch 7 and 22 corrupted; latency counts the accept cycle
    corrupt = 1'b1;
    base = wr_cnt;
    send(2'b10, 8'd0, 32'hFFFF_FE0C);
    chk("bc_first_ch", 32'(bus.threshold_ch), 32'd0);
    wait_rsp(k);
    chk("bc_latency", k + 1, 32'd161);
    chk("bc_pulses", wr_cnt - base, 32'd40);
    chk("bc_last_wr_ch", 32'(last_wr_ch), 32'd39);
    chk("bc_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("bc_rsp_ch", 32'(bus.rsp_ch), 32'd7);
    chk("bc_rsp_data", bus.rsp_data, 32'd2);
    finish_rsp;
    corrupt = 1'b0;

    send(2'b01, 8'd22, 32'd0);
    wait_rsp(k);
    chk("rd22_data", bus.rsp_data, 32'hFFFF_FE0D);
    finish_rsp;

    // reset in the middle of a broadcast write phase at ch15
    send(2'b10, 8'd0, 32'd9);
    k = 0;
    while (bus.threshold_ch != 8'd15 && k < 100) begin
      step;
      k++;
    end
    chk("mid_ch15", 32'(bus.threshold_ch), 32'd15);
    chk("mid_wtv", 32'(bus.write_threshold_value), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_wtv", 32'(bus.write_threshold_value), 32'd0);
    chk("async_th_ch", 32'(bus.threshold_ch), 32'd0);
    chk("async_th_val", bus.threshold_value, 32'd0);
    chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    step;
    rst_n = 1'b1;
    step;
    chk("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_no_rsp", 32'(bus.rsp_valid), 32'd0);

    send(2'b01, 8'd5, 32'd0);
    wait_rsp(k);
    chk("post_rd5_lat", k, 32'd3);
    chk("post_rd5_data", bus.rsp_data, 32'd9);
    finish_rsp;
    send(2'b01, 8'd15, 32'd0);
    wait_rsp(k);
    chk("post_rd15_data", bus.rsp_data, 32'hFFFF_FE0C);
    finish_rsp;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/threshold_config_sequencer.md
THRESHOLD_CONFIG_SEQUENCER -- requirements
Module: threshold_config_sequencer

Interface
REQ-001 Parameter NUM_CH, default 40: number of threshold channels addressable downstream.
REQ-002 Parameter TH_W, default 32: threshold word width, signed.
REQ-003 Ports: clk  in  1  single clock, all logic on rising edge; reset  in  1  asynchronous, active-low.
REQ-004 cmd_valid  in  1  host command present.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 cmd_op  in  2  00 write single, 01 read single, 10 broadcast-write-and-verify, 11 reserved.
REQ-007 cmd_ch  in  8  target channel; cmd_value  in  TH_W  signed write value.
REQ-008 rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  TH_W; rsp_ch  out  8; rsp_err  out  1.
REQ-009 write_threshold_value  out  1; threshold_ch  out  8; threshold_value  out  TH_W  (to the filter/trigger threshold bank).
REQ-010 threshold_value_read  in  TH_W  registered readback from the threshold bank.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, WR, RD_ADDR, RD_WAIT, RD_CAP, BC_WR, BC_RD_ADDR, BC_RD_WAIT, BC_CMP, RSP.
REQ-013 cmd_ready shall be high only in IDLE; a command is captured in the handshake cycle.
REQ-014 Channel check: cmd_ch >= NUM_CH with op 00/01 -> RSP directly, rsp_err=1, rsp_data=0, no downstream access.
REQ-015 Op 11 -> RSP, rsp_err=1, rsp_data=0, no downstream access.
REQ-016 Write single: WR drives write_threshold_value=1 for exactly one cycle with threshold_ch=cmd_ch and threshold_value=cmd_value, then RSP with rsp_err=0 and rsp_data=cmd_value.
REQ-017 Read single:
- RD_ADDR drives threshold_ch with write_threshold_value=0.
- RD_WAIT lasts one cycle.
- RD_CAP samples threshold_value_read (second rising edge after threshold_ch changes) into rsp_data.
- Then RSP with rsp_err=0.
REQ-018 Broadcast, write phase: BC_WR issues NUM_CH consecutive one-cycle writes of cmd_value, channels 0..NUM_CH-1, one per clock.
REQ-019 Broadcast, verify phase: per channel 0..NUM_CH-1, sequence is BC_RD_ADDR, BC_RD_WAIT, BC_CMP; BC_CMP compares threshold_value_read with cmd_value as signed TH_W values.
REQ-020 Broadcast response:
- rsp_err=1 if any mismatch.
- rsp_ch = first mismatching channel (0 if none).
- rsp_data = mismatch count, zero-extended.
- Total latency from accept to rsp_valid = NUM_CH + 3*NUM_CH + 1 cycles.
REQ-021 Op 00/01 responses: rsp_ch = cmd_ch.
REQ-022 RSP holds rsp_valid=1 and all rsp_* stable until rsp_ready; same-cycle rsp_valid & rsp_ready -> IDLE next cycle; rsp_ready while not in RSP is ignored.
REQ-023 write_threshold_value shall be 0 in every state other than WR and BC_WR; the channel counter wraps only via terminal compare at NUM_CH-1, never past it.
REQ-024 threshold_ch and threshold_value hold their last driven values in IDLE and RSP.

Reset
REQ-025 Reset low asynchronously forces:
- IDLE state.
- write_threshold_value=0, threshold_ch=0, threshold_value=0.
- rsp_valid=0, rsp_data=0, rsp_ch=0, rsp_err=0.
- channel counter and mismatch count to 0.
REQ-026 Reset asserted mid-operation aborts the command with no response; after release, cmd_ready=1 at the first clock edge.

Structure
REQ-027 Shared package thr_cfg_pkg holds NUM_CH, TH_W, CH_W=8, the cmd_op encodings and the state enum type.
REQ-028 Single flat module, no sub-module; the downstream threshold bank is a bench model only.

Verification
REQ-029 Write 00, ch=5, value=1234 -> one write pulse with threshold_ch=5 and threshold_value=1234; rsp_err=0, rsp_data=1234.
REQ-030 Read 01, ch=5 after the above -> rsp_data=1234, rsp_ch=5; threshold_value_read is sampled exactly 2 edges after threshold_ch=5.
REQ-031 Read 01, ch=40 -> rsp_err=1, rsp_data=0, write_threshold_value never asserted, no ch change.
REQ-032 Broadcast 10, value=-500, bank model corrupts ch 7 and 22 -> 40 write pulses; rsp_err=1, rsp_ch=7, rsp_data=2; latency 161 cycles.
REQ-033 Hold rsp_ready low 10 cycles with cmd_valid=1 -> rsp stable and cmd_ready=0 throughout; second command accepted only after the rsp handshake.
REQ-034 Assert reset during broadcast at channel 15 -> outputs zero immediately (asynchronous); no rsp_valid; fresh command 01 works after release.
